alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/seq_pkg.sv | 23 ++
 rtl/instr_fifo.sv | 64 ++++++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and widths for the ALU instruction sequencer.
package seq_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned INSTR_W = OP_W + 3 * REG_W;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    // Field order fixes the bit positions: op[8:6], rd[5:4], rs1[3:2], rs2[1:0].
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead instruction queue; push is ignored when full, pop when empty.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues instructions and steps each through EXEC and WB, driving the datapath controls.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [OP_W-1:0]    alu_control,
    output logic [REG_W-1:0]   addr1,
    output logic [REG_W-1:0]   addr2,
    output logic [REG_W-1:0]   addr3,
    output logic               wr,
    input  logic               overflow,
    input  logic               carry,
    input  logic               flag_clr,
    output logic               ovf_sticky,
    output logic               carry_sticky,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt,
    output logic               busy
);

    state_e             state_q, state_d;
    instr_t             instr_q, instr_d;
    logic               wr_q, wr_d;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_dout;
    logic               push;
    logic               pop;

    assign push = in_valid && !fifo_full;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_instr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencing, flag accumulation and retire counting.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pop     = 1'b0;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    instr_d = instr_t'(fifo_dout);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    instr_d = instr_t'(fifo_dout);
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear coinciding with the EXEC-end sample leaves exactly the sampled flag.
        if (state_q == S_EXEC) begin
            ovf_d   = overflow | (ovf_q & ~flag_clr);
            carry_d = carry | (carry_q & ~flag_clr);
        end else if (flag_clr) begin
            ovf_d   = 1'b0;
            carry_d = 1'b0;
        end

        wr_d = (state_d == S_WB);
    end

    // State, instruction and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = !fifo_full;
    assign alu_control  = instr_q.op;
    assign addr1        = instr_q.rs1;
    assign addr2        = instr_q.rs2;
    assign addr3        = instr_q.rd;
    assign wr           = wr_q;
    assign retire       = wr_q;
    assign ovf_sticky   = ovf_q;
    assign carry_sticky = carry_q;
    assign retired_cnt  = cnt_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic [2:0] alu_control;
    logic [1:0] addr1, addr2, addr3;
    logic       wr;
    logic       overflow, carry, flag_clr;
    logic       ovf_sticky, carry_sticky;
    logic       retire;
    logic [7:0] retired_cnt;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [8:0] ret_log [$];
    logic       saw_full;
    logic [8:0] full_vec [8];
    logic [8:0] b2b_vec  [4];

    alu_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .alu_control  (alu_control),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .wr           (wr),
        .overflow     (overflow),
        .carry        (carry),
        .flag_clr     (flag_clr),
        .ovf_sticky   (ovf_sticky),
        .carry_sticky (carry_sticky),
        .retire       (retire),
        .retired_cnt  (retired_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Record each retiring instruction as {op, rd, rs1, rs2}, and note any full queue.
    always @(negedge clk) begin
        if (retire) ret_log.push_back({alu_control, addr3, addr1, addr2});
        if (!in_ready) saw_full = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction and hold it until accepted (bounded).
    task automatic push(input logic [8:0] ins);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0;
        overflow = 1'b0; carry = 1'b0; flag_clr = 1'b0;
        saw_full = 1'b0;
        full_vec = '{9'b000_00_01_10, 9'b001_01_10_11, 9'b010_10_11_00, 9'b011_11_00_01,
                     9'b100_00_10_01, 9'b101_01_11_10, 9'b110_10_00_11, 9'b111_11_01_00};
        b2b_vec  = '{9'b001_00_01_10, 9'b100_10_11_00, 9'b011_11_10_01, 9'b110_01_10_11};

        // Reset state
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_wr", 32'(wr), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(retired_cnt), 0);
        check("rst_outs", 32'({alu_control, addr1, addr2, addr3, ovf_sticky, carry_sticky}), 0);
        rst = 1'b0;

        // Single op: EXEC then WB then idle
        push(9'b010_11_01_10);
        check("single_busy_q", 32'(busy), 1);
        check("single_idle_wr", 32'(wr), 0);
        tick();
        check("exec_alu", 32'(alu_control), 2);
        check("exec_addr1", 32'(addr1), 1);
        check("exec_addr2", 32'(addr2), 2);
        check("exec_addr3", 32'(addr3), 3);
        check("exec_wr", 32'(wr), 0);
        check("exec_retire", 32'(retire), 0);
        tick();
        check("wb_wr", 32'(wr), 1);
        check("wb_retire", 32'(retire), 1);
        check("wb_alu", 32'(alu_control), 2);
        check("wb_addr3", 32'(addr3), 3);
        tick();
        check("single_cnt", 32'(retired_cnt), 1);
        check("single_busy", 32'(busy), 0);
        check("single_idle_wr0", 32'(wr), 0);

        // Back-to-back: four pushes, wr alternates, no idle bubble
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = b2b_vec[i];
            check("b2b_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_wr0", 32'(wr), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("b2b_wr_pattern", 32'(wr), 32'(k % 2));
            check("b2b_busy", 32'(busy), 1);
        end
        tick();
        check("b2b_idle", 32'(busy), 0);
        check("b2b_cnt", 32'(retired_cnt), 5);
        check("hold_alu", 32'(alu_control), 6);
        check("hold_addr1", 32'(addr1), 2);
        check("hold_addr2", 32'(addr2), 3);
        check("hold_addr3", 32'(addr3), 1);
        check("hold_wr", 32'(wr), 0);

        // Full queue: eight pushes back to back, order preserved
        rst = 1'b1; tick(); rst = 1'b0;
        ret_log.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) push(full_vec[i]);
        wait_idle();
        check("full_seen", 32'(saw_full), 1);
        check("full_count", 32'(ret_log.size()), 8);
        check("full_cnt", 32'(retired_cnt), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ret_log.size()) check("full_order", 32'(ret_log[i]), 32'(full_vec[i]));
        end

        // Sticky flags
        rst = 1'b1; tick(); rst = 1'b0;
        push(9'b000_00_00_00);
        tick();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        check("ovf_set", 32'(ovf_sticky), 1);
        check("carry_unset", 32'(carry_sticky), 0);
        carry = 1'b1;
        tick();
        carry = 1'b0;
        check("carry_not_in_wb", 32'(carry_sticky), 0);
        tick(); tick();
        check("ovf_holds", 32'(ovf_sticky), 1);
        push(9'b001_01_01_01);
        tick();
        carry = 1'b1; flag_clr = 1'b1;
        tick();
        carry = 1'b0; flag_clr = 1'b0;
        check("clr_vs_set_carry", 32'(carry_sticky), 1);
        check("clr_vs_set_ovf", 32'(ovf_sticky), 0);
        wait_idle();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_ovf", 32'(ovf_sticky), 0);
        check("clr_carry", 32'(carry_sticky), 0);

        // Reset during WB with two entries queued
        rst = 1'b1; tick(); rst = 1'b0;
        push(9'b001_00_00_00);
        push(9'b010_00_00_00);
        push(9'b011_00_00_00);
        check("mid_wb_wr", 32'(wr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_wr", 32'(wr), 0);
        check("abort_retire", 32'(retire), 0);
        check("abort_cnt", 32'(retired_cnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(in_ready), 1);
        tick();
        check("abort_stays_idle", 32'(busy), 0);
        push(9'b011_10_01_01);
        wait_idle();
        check("post_rst_cnt", 32'(retired_cnt), 1);
        check("post_rst_alu", 32'(alu_control), 3);
        check("post_rst_addr3", 32'(addr3), 2);

        // Counter wrap
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 255; i++) push(9'b101_01_10_11);
        wait_idle();
        check("cnt_255", 32'(retired_cnt), 255);
        push(9'b101_01_10_11);
        wait_idle();
        check("cnt_wrap", 32'(retired_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
